// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch (IF) stage.
// Holds the widths, the stall encodings, the FSM state type and the packed
// IF/ID payload that travels from the fetch FSM into the IF/ID register.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EXC_W   = 7;
  localparam int unsigned STALL_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(0);
  localparam logic [DATA_W-1:0] NOP_INST  = DATA_W'(0);

  // Exception vector bit 1 flags an address error on instruction load (AdEL).
  localparam logic [EXC_W-1:0] EXC_ADEL_MASK = EXC_W'(2);

  typedef enum logic [1:0] {
    IF_IDLE   = 2'd0,
    IF_WAIT   = 2'd1,
    IF_HOLD   = 2'd2,
    IF_CANCEL = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [EXC_W-1:0]  exc;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register with reset/flush/stall/bubble priority.
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   flush_i         clears the register to a bubble
//   stall_if_i      stall[1] (IF/ID stage)
//   stall_id_i      stall[2] (ID stage)
//   load_i          a fetched instruction is ready this cycle
//   load_data_i     payload to load {pc, inst, exc}
//   id_o            registered IF/ID contents
module if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush_i,
  input  logic   stall_if_i,
  input  logic   stall_id_i,
  input  logic   load_i,
  input  if_id_t load_data_i,
  output if_id_t id_o
);

  localparam if_id_t BUBBLE = {RESET_PC, NOP_INST, EXC_W'(0)};

  if_id_t id_q;

  // IF stalled while ID runs must feed ID a bubble, not a duplicate.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= BUBBLE;
    end else if (flush_i) begin
      id_q <= BUBBLE;
    end else if (stall_if_i == STOP && stall_id_i == NO_STOP) begin
      id_q <= BUBBLE;
    end else if (stall_if_i == STOP) begin
      id_q <= id_q;
    end else if (load_i) begin
      id_q <= load_data_i;
    end else begin
      id_q <= BUBBLE;
    end
  end

  assign id_o = id_q;

endmodule

// File: rtl/inst_fetch.sv
// IF stage: turns the registered fetch PC into one SRAM-like instruction-bus
// transaction (req/addr_ok/data_ok), stalls PC/IF while it is outstanding and
// drives the IF/ID register.
// Optional feature macro: IF_ADDR_CHECK_EN -- misaligned PCs raise AdEL
// without touching the bus; undefined, misaligned PCs are fetched as-is.
// Ports:
//   clk, reset                  core clock, synchronous active-high reset
//   stall[5:0], flush           pipeline control from the controller / CP0
//   i_pc, i_except              fetch PC and its exception vector
//   inst_req, inst_addr         bus request and address (combinational)
//   inst_addr_ok, inst_data_ok  bus address accept / read-data valid
//   inst_rdata                  bus read data
//   stallreq_if                 stall request for PC and IF (combinational)
//   id_pc, id_inst, id_except   IF/ID register outputs
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [EXC_W-1:0]   i_except,
  output logic               inst_req,
  output logic [ADDR_W-1:0]  inst_addr,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok,
  input  logic [DATA_W-1:0]  inst_rdata,
  output logic               stallreq_if,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [DATA_W-1:0]  id_inst,
  output logic [EXC_W-1:0]   id_except
);

  if_state_e state_q, state_d;
  if_id_t    hold_q, hold_d;
  if_id_t    fetched_c;
  if_id_t    load_data_c;
  if_id_t    if_id;
  logic      load_c;
  logic      misalign_c;
  logic      unused_stall;

  // Only the IF/ID and ID stall bits matter to this stage.
  assign unused_stall = ^{stall[5:3], stall[0]};

`ifdef IF_ADDR_CHECK_EN
  assign misalign_c = (i_pc[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign fetched_c = {i_pc, inst_rdata, i_except};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, bus request, stall request and IF/ID load selection.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    inst_req    = 1'b0;
    stallreq_if = 1'b0;
    load_c      = 1'b0;
    load_data_c = fetched_c;
    case (state_q)
      IF_IDLE: begin
        if (misalign_c) begin
          // Bus untouched; a nop carrying AdEL goes down the pipe instead.
          load_c      = 1'b1;
          load_data_c = {i_pc, NOP_INST, i_except | EXC_ADEL_MASK};
        end else begin
          stallreq_if = 1'b1;
          inst_req    = ~flush;
          if (!flush && inst_addr_ok) begin
            state_d = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        stallreq_if = ~inst_data_ok;
        if (flush) begin
          // Response still owed by the bus must be swallowed in CANCEL.
          state_d = inst_data_ok ? IF_IDLE : IF_CANCEL;
        end else if (inst_data_ok) begin
          if (stall[1] == STOP) begin
            hold_d  = fetched_c;
            state_d = IF_HOLD;
          end else begin
            load_c  = 1'b1;
            state_d = IF_IDLE;
          end
        end
      end
      IF_HOLD: begin
        if (flush) begin
          state_d = IF_IDLE;
        end else if (stall[1] == NO_STOP) begin
          load_c      = 1'b1;
          load_data_c = hold_q;
          state_d     = IF_IDLE;
        end
      end
      IF_CANCEL: begin
        if (inst_data_ok) begin
          state_d = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
    if (reset) begin
      inst_req    = 1'b0;
      stallreq_if = 1'b0;
    end
  end

  assign inst_addr = inst_req ? i_pc : ADDR_W'(0);

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .stall_if_i  (stall[1]),
    .stall_id_i  (stall[2]),
    .load_i      (load_c),
    .load_data_i (load_data_c),
    .id_o        (if_id)
  );

  assign id_pc     = if_id.pc;
  assign id_inst   = if_id.inst;
  assign id_except = if_id.exc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a transaction-level model of the fetch stage, an
// instruction-bus slave and a PC register drive the DUT; expected IF/ID
// loads go into a queue that a negedge monitor pops and compares.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BOOT_PC  = 32'hBFC0_0000;
  localparam logic [31:0] HANDLER  = 32'hBFC0_0380;
`ifdef IF_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  stall = 6'b0;
  logic        flush = 1'b0;
  logic [31:0] i_pc = BOOT_PC;
  logic [6:0]  i_except = 7'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'b0;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [6:0]  id_except;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .i_pc         (i_pc),
    .i_except     (i_except),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .stallreq_if  (stallreq_if),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_except    (id_except)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit done   = 1'b0;

  // Reference state: PC register, bus slave, and the one fetch in flight.
  logic [31:0] pc_m = BOOT_PC;
  bit          outstanding = 1'b0;
  logic [31:0] out_addr = 32'h0;
  bit          pend_valid = 1'b0;
  bit          pend_has = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  logic [31:0] pend_data = 32'h0;
  logic [6:0]  pend_exc = 7'h0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [70:0] exp_q[$];

  function automatic void chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == BOOT_PC) return 32'h2402_0001;
    return (a ^ 32'hA5A5_0F0F) + 32'h0000_0101;
  endfunction

  function automatic logic [6:0] exc_of(input logic [31:0] pc);
    return {pc[9:5], 2'b00};
  endfunction

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input logic rst, input logic fl, input int unsigned lvl,
                      input logic aok, input logic dok);
    logic        sreq, req, dok_c, idle, misal, exp_req, exp_sreq;
    logic [31:0] addr;
    reset        = rst;
    flush        = fl & ~rst;
    inst_addr_ok = aok;
    dok_c        = dok & outstanding & ~rst;
    inst_data_ok = dok_c;
    // A response to a flushed request carries poison data.
    inst_rdata   = !dok_c ? $urandom : (pend_valid ? mem(out_addr) : 32'hDEAD_BEEF);
    i_pc         = pc_m;
    i_except     = exc_of(pc_m);
    #1;
    sreq  = stallreq_if;
    stall = 6'((32'd1 << lvl) - 32'd1) | (sreq ? 6'b000011 : 6'b000000);
    #1;
    req  = inst_req;
    addr = inst_addr;
    idle  = !outstanding && !pend_valid;
    misal = ADDR_CHK && (pc_m[1:0] != 2'b00);
    exp_req  = !rst && idle && !flush && !misal;
    exp_sreq = !rst && ((idle && !misal) || (outstanding && pend_valid && !dok_c));
    chk("inst_req", 71'(req), 71'(exp_req));
    chk("stallreq_if", 71'(sreq), 71'(exp_sreq));
    if (rst) chk("inst_addr_reset", 71'(addr), 71'(0));
    else if (req) chk("inst_addr", 71'(addr), 71'(pc_m));
    if (req && prev_wait) chk("addr_stable", 71'(addr), 71'(prev_addr));
    prev_wait = req && !aok && !rst;
    prev_addr = addr;
    if (rst) begin
      outstanding = 1'b0;
      pend_valid  = 1'b0;
      pc_m        = BOOT_PC;
    end else begin
      if (flush) begin
        pend_valid = 1'b0;
      end else if (pend_valid) begin
        if (dok_c) begin
          pend_has  = 1'b1;
          pend_data = inst_rdata;
        end
        if (pend_has && !stall[1]) begin
          exp_q.push_back({pend_pc, pend_data, pend_exc});
          pend_valid = 1'b0;
        end
      end else if (misal && idle && !stall[1]) begin
        exp_q.push_back({pc_m, 32'h0, i_except | 7'b0000010});
      end
      if (dok_c) outstanding = 1'b0;
      if (req && aok) begin
        outstanding = 1'b1;
        out_addr    = addr;
        pend_valid  = 1'b1;
        pend_has    = 1'b0;
        pend_pc     = pc_m;
        pend_exc    = i_except;
      end
      if (flush) pc_m = HANDLER;
      else if (!stall[0]) pc_m = pc_m + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: judges the IF/ID register after each edge from that edge's controls.
  logic        m_armed = 1'b0;
  logic        l_rst, l_fl;
  logic [5:0]  l_stall;
  logic [70:0] l_id;
  logic [70:0] cur;
  always @(negedge clk) begin
    if (!done) begin
      cur = {id_pc, id_inst, id_except};
      if (m_armed) begin
        if (l_rst || l_fl || (l_stall[1] && !l_stall[2])) begin
          chk("id_bubble", cur, {RESET_PC, 32'h0, 7'h0});
        end else if (l_stall[1]) begin
          chk("id_hold", cur, l_id);
        end else if (cur != {RESET_PC, 32'h0, 7'h0}) begin
          if (exp_q.size() == 0) chk("id_unexpected_load", cur, {RESET_PC, 32'h0, 7'h0});
          else chk("id_load", cur, exp_q.pop_front());
        end
      end
      l_rst   = reset;
      l_fl    = flush;
      l_stall = stall;
      l_id    = cur;
      m_armed = 1'b1;
    end
  end

  initial begin
    int unsigned lvl;
    logic        r_rst, r_fl, r_aok, r_dok;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Best-case fetch of the boot vector.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("t1_id_pc", 71'(id_pc), 71'(BOOT_PC));
    chk("t1_id_inst", 71'(id_inst), 71'(32'h2402_0001));
    // Address accept delayed three cycles.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    // Data returns while IF/ID and ID are stalled.
    step(0, 0, 0, 1, 0);
    step(0, 0, 3, 0, 1);
    step(0, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0);
    // Flush while waiting; poisoned response must be discarded.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    // Reset in the middle of a transaction.
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Randomized traffic, with a misaligned-PC stretch in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        step(1, 0, 0, 0, 0);
        pc_m = 32'hBFC0_1002;
      end
      r_rst = ($urandom_range(0, 299) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      lvl   = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 6);
      r_aok = $urandom_range(0, 1) == 1;
      r_dok = $urandom_range(0, 9) < 4;
      step(r_rst, r_fl, lvl, r_aok, r_dok);
    end
    // Drain: let any fetch in flight complete.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 71'(exp_q.size()), 71'(0));
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
